// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, parity modes and
// the bit-period rounding helper used by both TX and the future RX.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounds to the nearest whole number of clocks per bit so that the
  // baud error stays below half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts enabled clocks and flags the last clock of each
// bit period. Kept free of any TX knowledge so the receiver can reuse it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_tick = en && (r_cnt == LAST);

  // Free-running modulo counter, restarted by clr so a new frame always
  // begins on a clean bit boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter. Takes one byte per start/ready handshake and
// shifts it out LSB first with optional parity and one or two stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_o
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_badClksPerBit
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_badStopBits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_badParity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
  endgenerate

  tx_state_e  r_state;
  logic [7:0] r_shift;
  logic       r_parity;
  logic [2:0] r_bitCnt;
  logic       r_tx;
  logic       r_ready;
  logic       r_done;

  logic       w_accept;
  logic       w_bitTick;

  assign w_accept   = r_ready && tx_start_i;
  assign tx_ready_o = r_ready;
  assign tx_done_o  = r_done;
  assign tx_o       = r_tx;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudTick (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (w_accept),
    .en      (r_state != ST_IDLE),
    .bit_tick(w_bitTick)
  );

  // Frame sequencer: every output is registered, so each line level is set
  // on the bit tick that ends the previous bit and the start bit appears
  // the cycle after acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_bitCnt <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_start_i) begin
            r_shift  <= tx_data_i;
            r_parity <= (PARITY == PAR_ODD) ? ~(^tx_data_i) : (^tx_data_i);
            r_bitCnt <= '0;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_bitTick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bitTick) begin
            if (r_bitCnt == 3'd7) begin
              r_bitCnt <= '0;
              if (PARITY != PAR_NONE) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bitTick) begin
            r_tx     <= 1'b1;
            r_bitCnt <= '0;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bitTick) begin
            if (r_bitCnt == 3'(STOP_BITS - 1)) begin
              r_bitCnt <= '0;
              r_done   <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three instances at 10 clocks per
// bit covering no parity, even parity with two stop bits, and odd parity.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] startV;
  logic [7:0] dataV [3];
  wire  [2:0] txV;
  wire  [2:0] readyV;
  wire  [2:0] doneV;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLK_FREQ(1000), .BAUD(100), .PARITY(PAR_NONE), .STOP_BITS(1)
  ) dutNone (
    .clk(clk), .rstn(rstn), .tx_start_i(startV[0]), .tx_data_i(dataV[0]),
    .tx_ready_o(readyV[0]), .tx_done_o(doneV[0]), .tx_o(txV[0])
  );

  uart_tx_serializer #(
    .CLK_FREQ(1000), .BAUD(100), .PARITY(PAR_EVEN), .STOP_BITS(2)
  ) dutEven (
    .clk(clk), .rstn(rstn), .tx_start_i(startV[1]), .tx_data_i(dataV[1]),
    .tx_ready_o(readyV[1]), .tx_done_o(doneV[1]), .tx_o(txV[1])
  );

  uart_tx_serializer #(
    .CLK_FREQ(1000), .BAUD(100), .PARITY(PAR_ODD), .STOP_BITS(1)
  ) dutOdd (
    .clk(clk), .rstn(rstn), .tx_start_i(startV[2]), .tx_data_i(dataV[2]),
    .tx_ready_o(readyV[2]), .tx_done_o(doneV[2]), .tx_o(txV[2])
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a byte with start high; the following edge accepts it.
  task automatic applyStimulus(input int idx, input logic [7:0] data);
    startV[idx] = 1'b1;
    dataV[idx]  = data;
    tick();
  endtask

  // Called one cycle after acceptance. Checks each bit level over its 10
  // cycles, ready low and done low throughout, then done/ready/idle-high.
  // pokeAt >= 0 pulses a 0xFF request for two cycles at that frame cycle.
  task automatic checkFrame(input int idx, input logic [7:0] data, input bit hasPar,
                            input logic expPar, input int stopBits, input int pokeAt,
                            input string tag);
    logic expBits [12];
    int   nBits;
    int   ok;
    int   k;
    int   readyHi;
    int   doneHi;
    expBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) expBits[1 + i] = data[i];
    nBits = 9;
    if (hasPar) begin
      expBits[9] = expPar;
      nBits = 10;
    end
    for (int s = 0; s < stopBits; s++) begin
      expBits[nBits] = 1'b1;
      nBits++;
    end
    readyHi = 0;
    doneHi  = 0;
    for (int b = 0; b < nBits; b++) begin
      ok = 0;
      for (int c = 0; c < 10; c++) begin
        k = b * 10 + c;
        if (txV[idx] === expBits[b]) ok++;
        if (readyV[idx] !== 1'b0) readyHi++;
        if (doneV[idx] !== 1'b0) doneHi++;
        if (pokeAt >= 0 && k == pokeAt) begin
          startV[idx] = 1'b1;
          dataV[idx]  = 8'hFF;
        end
        if (pokeAt >= 0 && k == pokeAt + 2) startV[idx] = 1'b0;
        tick();
      end
      checkOutput($sformatf("%s_bit%0d_cycles", tag, b), ok, 10);
    end
    checkOutput({tag, "_ready_in_frame"}, readyHi, 0);
    checkOutput({tag, "_done_in_frame"}, doneHi, 0);
    checkOutput({tag, "_done_at_end"}, doneV[idx], 1);
    checkOutput({tag, "_ready_at_end"}, readyV[idx], 1);
    checkOutput({tag, "_tx_idle_gap"}, txV[idx], 1);
  endtask

  // Watch an idle line for a number of cycles: must stay high and ready.
  task automatic checkIdle(input int idx, input int cycles, input string tag);
    int lows;
    int notReady;
    lows = 0;
    notReady = 0;
    for (int c = 0; c < cycles; c++) begin
      if (txV[idx] !== 1'b1) lows++;
      if (readyV[idx] !== 1'b1) notReady++;
      tick();
    end
    checkOutput({tag, "_tx_low_cycles"}, lows, 0);
    checkOutput({tag, "_not_ready_cycles"}, notReady, 0);
  endtask

  initial begin
    rstn   = 1'b0;
    startV = '0;
    for (int i = 0; i < 3; i++) dataV[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_tx_%0d", i), txV[i], 1);
      checkOutput($sformatf("reset_ready_%0d", i), readyV[i], 1);
      checkOutput($sformatf("reset_done_%0d", i), doneV[i], 0);
    end
    rstn = 1'b1;
    tick();

    // 0x55, 8N1: alternating 0,1,... for 100 cycles
    applyStimulus(0, 8'h55);
    startV[0] = 1'b0;
    checkFrame(0, 8'h55, 1'b0, 1'b0, 1, -1, "single55");
    tick();
    checkOutput("single55_done_one_cycle", doneV[0], 0);

    // 0x07, even parity -> parity bit 1, two stop bits, 120 cycles
    applyStimulus(1, 8'h07);
    startV[1] = 1'b0;
    checkFrame(1, 8'h07, 1'b1, 1'b1, 2, -1, "even07");
    tick();

    // 0x07, odd parity -> parity bit 0
    applyStimulus(2, 8'h07);
    startV[2] = 1'b0;
    checkFrame(2, 8'h07, 1'b1, 1'b0, 1, -1, "odd07");
    tick();

    // Back-to-back with start held; data changed mid-frame to the next byte
    applyStimulus(0, 8'hA5);
    dataV[0] = 8'h3C;
    checkFrame(0, 8'hA5, 1'b0, 1'b0, 1, -1, "b2bFirst");
    tick();
    startV[0] = 1'b0;
    checkFrame(0, 8'h3C, 1'b0, 1'b0, 1, -1, "b2bSecond");
    checkIdle(0, 5, "b2bAfter");

    // Request during DATA of a 0x00 frame is ignored
    applyStimulus(0, 8'h00);
    startV[0] = 1'b0;
    checkFrame(0, 8'h00, 1'b0, 1'b0, 1, 35, "ignored");
    checkIdle(0, 20, "ignoredAfter");

    // Reset during data bit 3 of 0x00
    applyStimulus(0, 8'h00);
    startV[0] = 1'b0;
    repeat (43) tick();
    checkOutput("midreset_tx_before", txV[0], 0);
    checkOutput("midreset_ready_before", readyV[0], 0);
    rstn = 1'b0;
    #1;
    checkOutput("midreset_tx_async", txV[0], 1);
    checkOutput("midreset_ready_async", readyV[0], 1);
    checkOutput("midreset_done_async", doneV[0], 0);
    tick();
    tick();
    rstn = 1'b1;
    checkIdle(0, 120, "midresetAfter");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
